gcbp_corr_rd_seq: RTL and testbench

GCBP_CORR_RD_SEQ -- requirements
Module: gcbp_corr_rd_seq

---
 rtl/gcbp_corr_rd_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_gcbp_corr_rd_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcbp_corr_rd_seq.sv
// ----------------------------------------------------------------------------
// gcbp_corr_rd_seq
//
// BRAM read sequencer for the vertical-shift correlation sweep. After a
// frame is complete, it walks every candidate vertical shift s = 0..2R. For
// each shift it reads the overlapping subimage lines l = R..C_LINES-1-R from
// both the current-frame and previous-frame BRAM locations. The previous-frame
// line is offset by (s - R), so shift index R is the zero-displacement case.
//
// The read strobe and addresses are driven in the same cycle as the beat.
// The shift index and last-line marker are delayed to line up with the BRAM
// read data (o_line_valid). This lets the downstream accumulator consume beats
// directly.
//
// Optional feature (macro GCBP_RD_OVERRUN_CNT_EN):
//   When defined, the block adds an 8-bit saturating count of i_start pulses
//   that were ignored because a sweep was in progress. The count is cleared by
//   reset and by each accepted start.
//
// Ports:
//   i_clk, i_resetn          clock, async active-low reset
//   i_start                  frame complete, begin sweep (accepted in idle only)
//   i_curr_frame_loc [1:0]   BRAM location of the current frame
//   i_prev_frame_loc [1:0]   BRAM location of the previous frame
//   o_rd_en                  BRAM read enable (one per beat, no gaps)
//   o_curr_rd_addr  [8:0]    current-frame read address
//   o_prev_rd_addr  [8:0]    previous-frame read address
//   o_line_valid             read data for a beat is valid (o_rd_en delayed)
//   o_shift_idx     [4:0]    shift index aligned to o_line_valid
//   o_shift_last             last line of a shift, aligned to o_line_valid
//   o_busy                   sweep in progress (cycle after start .. done)
//   o_overrun_cnt   [7:0]    ignored-start count (GCBP_RD_OVERRUN_CNT_EN only)
//   o_done                   one-cycle pulse closing the sweep
// ----------------------------------------------------------------------------
module gcbp_corr_rd_seq #(
  parameter int C_LINES                   = 64,
  parameter int C_SEARCH_RANGE            = 4,
  parameter int C_SUBIMAGE_OFFSET_IN_BRAM = 128,
  parameter int C_RD_LATENCY              = 1
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_start,
  input  logic [1:0] i_curr_frame_loc,
  input  logic [1:0] i_prev_frame_loc,
  output logic       o_rd_en,
  output logic [8:0] o_curr_rd_addr,
  output logic [8:0] o_prev_rd_addr,
  output logic       o_line_valid,
  output logic [4:0] o_shift_idx,
  output logic       o_shift_last,
  output logic       o_busy,
`ifdef GCBP_RD_OVERRUN_CNT_EN
  output logic [7:0] o_overrun_cnt,
`endif
  output logic       o_done
);

  localparam int LAT = C_RD_LATENCY;

  localparam logic [8:0] R9      = 9'(C_SEARCH_RANGE);
  localparam logic [8:0] OFF9    = 9'(C_SUBIMAGE_OFFSET_IN_BRAM);
  localparam logic [8:0] L_FIRST = 9'(C_SEARCH_RANGE);
  localparam logic [8:0] L_LAST  = 9'(C_LINES - 1 - C_SEARCH_RANGE);
  localparam logic [4:0] S_LAST  = 5'(2 * C_SEARCH_RANGE);
  localparam logic [2:0] D_LAST  = 3'(C_RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state, state_nxt;

  logic [4:0] s_cnt;
  logic [8:0] l_cnt;
  logic [4:0] nxt_s;
  logic [8:0] nxt_l;
  logic [1:0] curr_loc, prev_loc;
  logic [2:0] drain_cnt;

  logic       start_acc;
  logic       line_end;
  logic       last_beat;

  // Base word address of a frame location, kept to 9 bits like the BRAM port.
  function automatic logic [8:0] loc_base(input logic [1:0] loc);
    return 9'(loc) * OFF9;
  endfunction

  assign start_acc = (state == S_IDLE) && i_start;
  assign line_end  = (l_cnt == L_LAST);
  assign last_beat = line_end && (s_cnt == S_LAST);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start)              state_nxt = S_READ;
      S_READ:  if (last_beat)            state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == D_LAST)  state_nxt = S_DONE;
      S_DONE:                            state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_rd_en = 1'b0;
    o_done  = 1'b0;
    o_busy  = 1'b0;
    case (state)
      S_READ:  begin o_rd_en = 1'b1; o_busy = 1'b1; end
      S_DRAIN: begin                 o_busy = 1'b1; end
      S_DONE:  begin o_done  = 1'b1; o_busy = 1'b1; end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Line / shift counters and latched frame locations
  // --------------------------------------------------------------------------
  // The coordinates of the beat after the current one. They are used to
  // preload the address registers so each READ cycle shows its own address.
  always_comb begin
    nxt_s = s_cnt;
    nxt_l = l_cnt + 9'd1;
    if (line_end) begin
      nxt_s = s_cnt + 5'd1;
      nxt_l = L_FIRST;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      s_cnt    <= '0;
      l_cnt    <= '0;
      curr_loc <= '0;
      prev_loc <= '0;
    end else if (start_acc) begin
      s_cnt    <= '0;
      l_cnt    <= L_FIRST;
      curr_loc <= i_curr_frame_loc;
      prev_loc <= i_prev_frame_loc;
    end else if (state == S_READ && !last_beat) begin
      s_cnt    <= nxt_s;
      l_cnt    <= nxt_l;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)              drain_cnt <= '0;
    else if (state == S_DRAIN)  drain_cnt <= drain_cnt + 3'd1;
    else                        drain_cnt <= '0;
  end

  // --------------------------------------------------------------------------
  // Address registers
  // --------------------------------------------------------------------------
  // Loaded one beat ahead, so they hold the address of the beat in flight.
  // On the final beat they are left alone, so both ports keep their last
  // address through drain, done and idle.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_curr_rd_addr <= '0;
      o_prev_rd_addr <= '0;
    end else if (start_acc) begin
      // First beat: s = 0, l = R, so the previous-frame offset l+s-R is 0.
      o_curr_rd_addr <= loc_base(i_curr_frame_loc) + L_FIRST;
      o_prev_rd_addr <= loc_base(i_prev_frame_loc) + L_FIRST - R9;
    end else if (state == S_READ && !last_beat) begin
      o_curr_rd_addr <= loc_base(curr_loc) + nxt_l;
      o_prev_rd_addr <= loc_base(prev_loc) + nxt_l + {4'b0, nxt_s} - R9;
    end
  end

  // --------------------------------------------------------------------------
  // Read-latency alignment pipeline
  // --------------------------------------------------------------------------
  logic [LAT:1]       vld_pipe;
  logic [LAT:1][4:0]  sidx_pipe;
  logic [LAT:1]       slast_pipe;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      vld_pipe   <= '0;
      sidx_pipe  <= '0;
      slast_pipe <= '0;
    end else begin
      vld_pipe[1]   <= o_rd_en;
      sidx_pipe[1]  <= s_cnt;
      slast_pipe[1] <= line_end;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        sidx_pipe[i]  <= sidx_pipe[i-1];
        slast_pipe[i] <= slast_pipe[i-1];
      end
    end
  end

  assign o_line_valid = vld_pipe[LAT];
  assign o_shift_idx  = sidx_pipe[LAT];
  assign o_shift_last = slast_pipe[LAT];

  // --------------------------------------------------------------------------
  // Ignored-start counter
  // --------------------------------------------------------------------------
`ifdef GCBP_RD_OVERRUN_CNT_EN
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)
      o_overrun_cnt <= '0;
    else if (start_acc)
      o_overrun_cnt <= '0;
    else if (i_start && state != S_IDLE && o_overrun_cnt != 8'hFF)
      o_overrun_cnt <= o_overrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_gcbp_corr_rd_seq.sv
// ----------------------------------------------------------------------------
// Testbench for gcbp_corr_rd_seq.
//
// Stimulus pushes the expected beats (addresses, shift index and last flag)
// into queues. A monitor running on the falling edge pops them whenever the
// DUT strobes o_rd_en or o_line_valid.
//
// A second instance with C_RD_LATENCY=3 shares the same inputs. It is checked
// against a 3-deep delay of its own o_rd_en, and its done pulse is checked
// relative to its last read.
// ----------------------------------------------------------------------------
module tb_gcbp_corr_rd_seq;

  localparam int LINES = 64;
  localparam int R     = 4;
  localparam int OFF   = 128;

  logic       i_clk    = 1'b0;
  logic       i_resetn = 1'b0;
  logic       i_start  = 1'b0;
  logic [1:0] curr_loc = 2'd0;
  logic [1:0] prev_loc = 2'd0;

  logic       rd_en, lv, slast, busy, done;
  logic [8:0] ca, pa;
  logic [4:0] sidx;
  logic       rd_en3, lv3, slast3, busy3, done3;
  logic [8:0] ca3, pa3;
  logic [4:0] sidx3;
`ifdef GCBP_RD_OVERRUN_CNT_EN
  logic [7:0] ovr, ovr3;
`endif

  gcbp_corr_rd_seq dut (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_start(i_start),
    .i_curr_frame_loc(curr_loc), .i_prev_frame_loc(prev_loc),
    .o_rd_en(rd_en), .o_curr_rd_addr(ca), .o_prev_rd_addr(pa),
    .o_line_valid(lv), .o_shift_idx(sidx), .o_shift_last(slast),
    .o_busy(busy),
`ifdef GCBP_RD_OVERRUN_CNT_EN
    .o_overrun_cnt(ovr),
`endif
    .o_done(done)
  );

  gcbp_corr_rd_seq #(.C_RD_LATENCY(3)) dut3 (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_start(i_start),
    .i_curr_frame_loc(curr_loc), .i_prev_frame_loc(prev_loc),
    .o_rd_en(rd_en3), .o_curr_rd_addr(ca3), .o_prev_rd_addr(pa3),
    .o_line_valid(lv3), .o_shift_idx(sidx3), .o_shift_last(slast3),
    .o_busy(busy3),
`ifdef GCBP_RD_OVERRUN_CNT_EN
    .o_overrun_cnt(ovr3),
`endif
    .o_done(done3)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endfunction

  typedef struct { int ca; int pa; } rd_t;
  typedef struct { int s; int last; } lv_t;
  rd_t rd_q[$];
  lv_t lv_q[$];

  // Monitor state
  int cyc = 0, rd_cnt = 0, last_cnt = 0, done_cnt = 0;
  int last_lv_cyc = 0, last_rd_cyc = 0, last_rd3 = 0;
  int first_ca = 0, first_pa = 0, last_ca = 0, last_pa = 0;
  bit prev_rd = 0, cont = 0, gap_ref = 0;
  bit [2:0] lag3 = '0;

  task automatic push_sweep(input int c, input int p);
    rd_t r;
    lv_t v;
    for (int s = 0; s <= 2*R; s++)
      for (int l = R; l <= LINES-1-R; l++) begin
        r.ca = c*OFF + l;
        r.pa = p*OFF + l + s - R;
        v.s = s;
        v.last = (l == LINES-1-R) ? 1 : 0;
        rd_q.push_back(r);
        lv_q.push_back(v);
      end
  endtask

  always @(negedge i_clk) begin
    cyc++;
    if (rd_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        rd_t e;
        e = rd_q.pop_front();
        chk("curr_addr", int'(ca), e.ca);
        chk("prev_addr", int'(pa), e.pa);
      end
      if (rd_cnt == 0) begin first_ca = int'(ca); first_pa = int'(pa); end
      last_ca = int'(ca);
      last_pa = int'(pa);
      rd_cnt++;
      if (cont && gap_ref && !prev_rd) chk("sweep_gap", cyc - last_rd_cyc, 4);
      last_rd_cyc = cyc;
      gap_ref = 1;
    end
    prev_rd = rd_en;
    if (lv) begin
      if (lv_q.size() == 0) chk("lv_unexpected", 1, 0);
      else begin
        lv_t e;
        e = lv_q.pop_front();
        chk("shift_idx", int'(sidx), e.s);
        chk("shift_last", int'(slast), e.last);
      end
      if (slast) last_cnt++;
      last_lv_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      chk("done_after_lv", cyc - last_lv_cyc, 1);
    end
    // latency-3 instance
    if (!i_resetn) lag3 = '0;
    else begin
      chk("lv3_lag", int'(lv3), int'(lag3[2]));
      lag3 = {lag3[1:0], rd_en3};
    end
    if (rd_en3) last_rd3 = cyc;
    if (done3) chk("drain3", cyc - last_rd3, 4);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start(input int c, input int p);
    curr_loc = 2'(c);
    prev_loc = 2'(p);
    i_start  = 1'b1;
    tick(1);
    i_start  = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rd_en"}, int'(rd_en), 0);
    chk({nm, "_curr"},  int'(ca), 0);
    chk({nm, "_prev"},  int'(pa), 0);
    chk({nm, "_lv"},    int'(lv), 0);
    chk({nm, "_sidx"},  int'(sidx), 0);
    chk({nm, "_slast"}, int'(slast), 0);
    chk({nm, "_busy"},  int'(busy), 0);
    chk({nm, "_done"},  int'(done), 0);
    chk({nm, "_lv3"},   int'(lv3), 0);
    chk({nm, "_busy3"}, int'(busy3), 0);
`ifdef GCBP_RD_OVERRUN_CNT_EN
    chk({nm, "_ovr"},   int'(ovr), 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int d;
    int n;
    tick(3);
    chk_all_zero("reset");
    i_resetn = 1'b1;
    tick(2);

    // 1: defaults, curr=1 prev=2, location inputs change mid-sweep
    rd_cnt = 0; last_cnt = 0;
    push_sweep(1, 2);
    pulse_start(1, 2);
    chk("busy_after_start", int'(busy), 1);
    curr_loc = 2'd3;
    prev_loc = 2'd0;
    wait_done(1, 700);
    chk("s1_beats", rd_cnt, 504);
    chk("s1_shift_last", last_cnt, 9);
    chk("s1_first_curr", first_ca, 132);
    chk("s1_first_prev", first_pa, 256);
    chk("s1_last_curr", last_ca, 187);
    chk("s1_last_prev", last_pa, 319);
    chk("s1_queues", rd_q.size() + lv_q.size(), 0);
    tick(1);
    chk("s1_idle_busy", int'(busy), 0);
    chk("s1_addr_hold", int'(ca), 187);

    // 2: start pulses every 100 cycles during the sweep are ignored
    tick(4);
    rd_cnt = 0;
    push_sweep(2, 1);
    pulse_start(2, 1);
    repeat (5) begin
      tick(99);
      i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
    end
    wait_done(2, 700);
    chk("s2_beats", rd_cnt, 504);
    chk("s2_queues", rd_q.size() + lv_q.size(), 0);
`ifdef GCBP_RD_OVERRUN_CNT_EN
    chk("s2_overrun", int'(ovr), 5);
`endif

    // 3: start held high -> two back-to-back sweeps
    tick(8);
    rd_cnt = 0;
    cont = 1; gap_ref = 0;
    push_sweep(3, 1);
    push_sweep(3, 1);
    curr_loc = 2'd3;
    prev_loc = 2'd1;
    i_start = 1'b1;
    wait_done(4, 1500);
    i_start = 1'b0;
    tick(5);
    cont = 0;
    chk("s3_beats", rd_cnt, 1008);
    chk("s3_queues", rd_q.size() + lv_q.size(), 0);
    chk("s3_idle_busy", int'(busy), 0);

    // 4: async reset at beat 200 discards the sweep
    tick(8);
    rd_cnt = 0;
    push_sweep(1, 2);
    pulse_start(1, 2);
    n = 0;
    while (rd_cnt < 200 && n < 400) begin tick(1); n++; end
    chk("s4_reach_200", (rd_cnt >= 200) ? 1 : 0, 1);
    #1 i_resetn = 1'b0;
    #1 chk_all_zero("midreset");
    d = done_cnt;
    tick(3);
    rd_q.delete();
    lv_q.delete();
    i_resetn = 1'b1;
    tick(20);
    chk("s4_no_done", done_cnt, d);
    chk("s4_idle_busy", int'(busy), 0);

    // 5: clean sweep after reset
    rd_cnt = 0; last_cnt = 0;
    push_sweep(0, 3);
    pulse_start(0, 3);
    wait_done(d + 1, 700);
    chk("s5_beats", rd_cnt, 504);
    chk("s5_shift_last", last_cnt, 9);
    chk("s5_first_curr", first_ca, 4);
    chk("s5_first_prev", first_pa, 384);
    chk("s5_queues", rd_q.size() + lv_q.size(), 0);
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
